// File: rtl/shared_memory_arbiter_pkg.sv
// Shared types and constants for the two-requester shared memory arbiter.
package shared_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  localparam int BURST_MAX_LIMIT = 15;
  localparam int BURST_CNT_W     = 4;

  // Out-of-range burst limits are clamped into 1..BURST_MAX_LIMIT.
  function automatic logic [BURST_CNT_W-1:0] burst_cap(input int burst_max);
    if (burst_max < 1)
      burst_cap = BURST_CNT_W'(1);
    else if (burst_max > BURST_MAX_LIMIT)
      burst_cap = BURST_CNT_W'(BURST_MAX_LIMIT);
    else
      burst_cap = BURST_CNT_W'(burst_max);
  endfunction

endpackage

// File: rtl/shmem_rr_grant.sv
// Ownership FSM for the arbiter: round-robin on contention, burst-limited ownership.
//   state   | meaning
//   IDLE    | no owner; next request(s) arbitrated fresh, loser of last contest wins ties
//   OWN0    | m0 owns the memory until it drops its request or its burst is spent
//   OWN1    | m1 owns the memory until it drops its request or its burst is spent
module shmem_rr_grant
  import shared_memory_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_req0,
  input  logic     i_req1,
  output logic     o_grant_vld,
  output req_idx_t o_grant_idx
);

  localparam logic [BURST_CNT_W-1:0] BURST_CAP = burst_cap(BURST_MAX);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  req_idx_t               r_last;
  logic [BURST_CNT_W-1:0] r_burst_cnt;

  req_idx_t w_own_idx;
  logic     w_own_req;
  logic     w_oth_req;
  logic     w_cap_hit;
  logic     w_change;

  always_comb begin
    w_own_idx   = (r_state == ST_OWN1);
    w_own_req   = w_own_idx ? i_req1 : i_req0;
    w_oth_req   = w_own_idx ? i_req0 : i_req1;
    w_cap_hit   = (r_burst_cnt >= BURST_CAP);
    o_grant_vld = 1'b0;
    o_grant_idx = r_last;
    w_change    = 1'b0;
    w_state_nxt = ST_IDLE;

    if (r_state == ST_IDLE) begin
      if (i_req0 || i_req1) begin
        o_grant_vld = 1'b1;
        o_grant_idx = (i_req0 && i_req1) ? ~r_last : i_req1;
        w_change    = 1'b1;
      end
    end else if (w_own_req && !(w_cap_hit && w_oth_req)) begin
      o_grant_vld = 1'b1;
      o_grant_idx = w_own_idx;
    end else if (w_oth_req) begin
      // Owner done or burst spent: hand over this cycle so no memory slot is lost.
      o_grant_vld = 1'b1;
      o_grant_idx = ~w_own_idx;
      w_change    = 1'b1;
    end

    if (reset)
      o_grant_vld = 1'b0;

    if (o_grant_vld)
      w_state_nxt = o_grant_idx ? ST_OWN1 : ST_OWN0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_grant_vld) begin
        r_last <= o_grant_idx;
        if (w_change)
          r_burst_cnt <= BURST_CNT_W'(1);
        else if (!w_cap_hit)
          r_burst_cnt <= r_burst_cnt + BURST_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Optional SHMEM_ARB_STATS_EN adds per-requester stall counters with a clear input.
module shared_memory_arbiter
  import shared_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
`ifdef SHMEM_ARB_STATS_EN
  input  logic                stats_clr,
  output logic [15:0]         stall_cnt0,
  output logic [15:0]         stall_cnt1,
`endif
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic     w_req0;
  logic     w_req1;
  logic     w_gnt_vld;
  req_idx_t w_gnt_idx;
  logic     w_win_write;
  logic     w_rd_acc;
  logic     r_rd_vld;
  req_idx_t r_rd_tag;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  shmem_rr_grant #(
    .BURST_MAX (BURST_MAX)
  ) u_grant (
    .clk         (clk),
    .reset       (reset),
    .i_req0      (w_req0),
    .i_req1      (w_req1),
    .o_grant_vld (w_gnt_vld),
    .o_grant_idx (w_gnt_idx)
  );

  assign m0_waitrequest = w_req0 & ~(w_gnt_vld & (w_gnt_idx == 1'b0));
  assign m1_waitrequest = w_req1 & ~(w_gnt_vld & (w_gnt_idx == 1'b1));

  // Write wins when a requester raises read and write together.
  assign w_win_write    = w_gnt_idx ? m1_write : m0_write;
  assign w_rd_acc       = w_gnt_vld & ~w_win_write;

  assign mem_address    = w_gnt_idx ? m1_address    : m0_address;
  assign mem_byteenable = w_gnt_idx ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt_idx ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_gnt_vld;
  assign mem_write      = w_gnt_vld & w_win_write;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_rd_tag <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_acc;
      r_rd_tag <= w_gnt_idx;
    end
  end

  // Gated by reset so a strobe pending when reset arrives is dropped immediately.
  assign m0_readdatavalid = r_rd_vld & ~reset & (r_rd_tag == 1'b0);
  assign m1_readdatavalid = r_rd_vld & ~reset & (r_rd_tag == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef SHMEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt0;
  logic [15:0] r_stall_cnt1;

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      r_stall_cnt0 <= '0;
      r_stall_cnt1 <= '0;
    end else begin
      if (w_req0 && m0_waitrequest && (r_stall_cnt0 != 16'hFFFF))
        r_stall_cnt0 <= r_stall_cnt0 + 16'd1;
      if (w_req1 && m1_waitrequest && (r_stall_cnt1 != 16'hFFFF))
        r_stall_cnt1 <= r_stall_cnt1 + 16'd1;
    end
  end

  assign stall_cnt0 = r_stall_cnt0;
  assign stall_cnt1 = r_stall_cnt1;
`endif

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Directed bench for shared_memory_arbiter with a behavioural single-port memory.
module tb_shared_memory_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              stats_clr;
  logic [15:0]       stall_cnt0, stall_cnt1;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] mem [0:1023];

  int n_cmp;
  int n_fail;

  shared_memory_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_MAX (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
`ifdef SHMEM_ARB_STATS_EN
    .stats_clr        (stats_clr),
    .stall_cnt0       (stall_cnt0),
    .stall_cnt1       (stall_cnt1),
`endif
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

`ifndef SHMEM_ARB_STATS_EN
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous memory: byte-lane writes, read data one cycle later.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       g;
    logic       prev_g;
    logic [4:0] exp5;

    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'hC0C0C0C0;
    mem[1] = 32'hA1A1A1A1;
    mem[2] = 32'hB2B2B2B2;
    reset = 1'b1;
    stats_clr = 1'b0;
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_wr", {mem_chipselect, mem_write}, 2'b00);
    chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk("rst_wait", {m1_waitrequest, m0_waitrequest}, 2'b00);

    // Continuous contention from reset: m1 x4, m0 x4, m1 x4.
    prev_g = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      reset = 1'b0;
      drv0(1'b1, 1'b0, 10'd0, 4'hF, '0);
      drv1(1'b1, 1'b0, 10'd1, 4'hF, '0);
      @(negedge clk);
      g = (c < 4 || c >= 8) ? 1'b1 : 1'b0;
      exp5 = {~g, g, 1'b1, (c == 0) ? 2'b00 : (prev_g ? 2'b10 : 2'b01)};
      chk($sformatf("burst_c%0d", c),
          {m1_waitrequest, m0_waitrequest, mem_chipselect, m1_readdatavalid, m0_readdatavalid}, exp5);
      if (c > 0) chk($sformatf("burst_data_c%0d", c), m0_readdata, prev_g ? 32'hA1A1A1A1 : 32'hC0C0C0C0);
      prev_g = g;
    end
    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("burst_tail_rdv", {mem_chipselect, m1_readdatavalid, m0_readdatavalid}, 3'b010);
    chk("burst_tail_data", m1_readdata, 32'hA1A1A1A1);

    // m0 write then read of the same address.
    next_cycle();
    drv0(1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr5_ctl", {m0_waitrequest, mem_chipselect, mem_write}, 3'b011);
    chk("wr5_addr", mem_address, 32'd5);
    next_cycle();
    drv0(1'b1, 1'b0, 10'd5, 4'hF, '0);
    @(negedge clk);
    chk("rd5_ctl", {m0_waitrequest, mem_chipselect, mem_write}, 3'b010);
    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("rd5_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
    chk("rd5_data", m0_readdata, 32'hDEADBEEF);

    // m1 partial byte write over a full word.
    next_cycle();
    drv1(1'b0, 1'b1, 10'd3, 4'hF, 32'h11223344);
    @(negedge clk);
    chk("wr3_ctl", {m1_waitrequest, mem_chipselect, mem_write}, 3'b011);
    next_cycle();
    drv1(1'b0, 1'b1, 10'd3, 4'h2, 32'h0000AA00);
    @(negedge clk);
    chk("wr3_be", mem_byteenable, 32'h2);
    next_cycle();
    drv1(1'b1, 1'b0, 10'd3, 4'hF, '0);
    @(negedge clk);
    next_cycle();
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("rd3_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
    chk("rd3_data", m1_readdata, 32'h1122AA44);

    // Read and write together: the write is performed, no read strobe follows.
    next_cycle();
    drv0(1'b1, 1'b1, 10'd7, 4'hF, 32'h00000055);
    @(negedge clk);
    chk("rw_both_wr", {mem_chipselect, mem_write}, 2'b11);
    next_cycle();
    drv0(1'b1, 1'b0, 10'd7, 4'hF, '0);
    @(negedge clk);
    chk("rw_both_nostrobe", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("rd7_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
    chk("rd7_data", m0_readdata, 32'h00000055);

    // Alternating single-cycle reads.
    next_cycle();
    drv0(1'b1, 1'b0, 10'd1, 4'hF, '0);
    @(negedge clk);
    chk("alt_k", {m1_waitrequest, m0_waitrequest, mem_chipselect, mem_address}, {3'b001, 10'd1});
    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b1, 1'b0, 10'd2, 4'hF, '0);
    @(negedge clk);
    chk("alt_l", {m1_waitrequest, mem_chipselect, mem_address, m1_readdatavalid, m0_readdatavalid},
        {2'b01, 10'd2, 2'b01});
    chk("alt_l_data", m0_readdata, 32'hA1A1A1A1);
    next_cycle();
    drv0(1'b1, 1'b0, 10'd1, 4'hF, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("alt_m", {m0_waitrequest, mem_chipselect, mem_address, m1_readdatavalid, m0_readdatavalid},
        {2'b01, 10'd1, 2'b10});
    chk("alt_m_data", m1_readdata, 32'hB2B2B2B2);
    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b1, 1'b0, 10'd2, 4'hF, '0);
    @(negedge clk);
    chk("alt_n", {m1_waitrequest, mem_chipselect, mem_address, m1_readdatavalid, m0_readdatavalid},
        {2'b01, 10'd2, 2'b01});
    chk("alt_n_data", m0_readdata, 32'hA1A1A1A1);
    next_cycle();
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("alt_o", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
    chk("alt_o_data", m1_readdata, 32'hB2B2B2B2);

    // Reset right after a read accept.
    next_cycle();
    drv1(1'b1, 1'b0, 10'd2, 4'hF, '0);
    @(negedge clk);
    chk("rst_p_acc", m1_waitrequest, 1'b0);
    next_cycle();
    reset = 1'b1;
    drv0(1'b1, 1'b0, 10'd1, 4'hF, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
    chk("rst_q", {m0_waitrequest, mem_chipselect, m1_readdatavalid, m0_readdatavalid}, 4'b1000);
    next_cycle();
    reset = 1'b0;
    drv1(1'b1, 1'b0, 10'd2, 4'hF, '0);
    @(negedge clk);
    chk("rst_r", {m1_waitrequest, m0_waitrequest, m1_readdatavalid, m0_readdatavalid}, 4'b0100);

    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    stats_clr = 1'b1;
    @(negedge clk);
    chk("rst_s_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);

    // Contention starting with m1 as last grant: m0 x4, m1 x4, m0 x3.
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      stats_clr = 1'b0;
      drv0(1'b1, 1'b0, 10'd0, 4'hF, '0);
      drv1(1'b1, 1'b0, 10'd1, 4'hF, '0);
      @(negedge clk);
      g = (c >= 4 && c < 8) ? 1'b1 : 1'b0;
      chk($sformatf("stall_c%0d", c), {m1_waitrequest, m0_waitrequest}, {~g, g});
    end
    next_cycle();
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
`ifdef SHMEM_ARB_STATS_EN
    chk("stall_cnt1", stall_cnt1, 32'd7);
    chk("stall_cnt0", stall_cnt0, 32'd4);
`endif
    next_cycle();
    drv0(1'b1, 1'b0, 10'd0, 4'hF, '0);
    drv1(1'b1, 1'b0, 10'd1, 4'hF, '0);
    stats_clr = 1'b1;
    @(negedge clk);
    chk("clr_cycle_grant", {m1_waitrequest, m0_waitrequest}, 2'b01);
    next_cycle();
    stats_clr = 1'b0;
    drv0(1'b0, 1'b0, '0, 4'h0, '0);
    drv1(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);
`ifdef SHMEM_ARB_STATS_EN
    chk("stall_clr", {stall_cnt1, stall_cnt0}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
